// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : laser_pkg
//  Description : Shared types for the laser pulse receiver: FSM state
//                encoding and error classification codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package laser_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OVER = 2'd2,
      GAP  = 2'd3
   } rx_state_t;

   // Classification of the most recent faulty pulse
   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_SHORT = 2'd1,
      ERR_LONG  = 2'd2,
      ERR_GAP   = 2'd3
   } rx_err_t;

endpackage : laser_pkg
`default_nettype wire

// File: rtl/laser_pulse_rx.sv
`default_nettype none
// ============================================================================
//  Module      : laser_pulse_rx
//  Description : Measures each high pulse on the beam line and the low gap
//                that follows, classifies it as good / short / long / gap
//                violation, strobes the result and counts good pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module laser_pulse_rx
   import laser_pkg::*;
#(
   parameter int PULSE_LEN = 3,
   parameter int MIN_GAP   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       beam,
   output logic       pulse_ok,
   output logic       pulse_err,
   output logic [1:0] err_code,
   output logic [7:0] ok_count,
   output logic       busy
);

   // Counter width covers the larger of the two measured lengths
   localparam int c_MAX_LEN = (PULSE_LEN > MIN_GAP) ? PULSE_LEN : MIN_GAP;
   localparam int CNT_W     = $clog2(c_MAX_LEN + 1);

   localparam logic [CNT_W-1:0] c_PULSE_LEN = CNT_W'(PULSE_LEN);
   localparam logic [CNT_W-1:0] c_RUN_ONE   = CNT_W'(1);
   localparam logic [CNT_W:0]   c_GAP_ONE   = (CNT_W+1)'(1);
   localparam logic [CNT_W:0]   c_MIN_GAP   = (CNT_W+1)'(MIN_GAP);
   // A single required low cycle is already satisfied by the falling sample
   localparam logic             c_GAP_SKIP  = (MIN_GAP == 1);

   rx_state_t        r_state;
   logic [CNT_W-1:0] r_run_cnt;
   logic [CNT_W-1:0] r_gap_cnt;
   logic             r_pulse_ok;
   logic             r_pulse_err;
   rx_err_t          r_err_code;
   logic [7:0]       r_ok_count;

   rx_state_t        w_state_nxt;
   logic [CNT_W-1:0] w_run_nxt;
   logic [CNT_W-1:0] w_gap_nxt;
   logic             w_ok;
   logic             w_err;
   rx_err_t          w_err_nxt;
   logic [CNT_W:0]   w_gap_p1;

   // Gap count including the current low sample, one bit wider so the
   // comparison against MIN_GAP cannot overflow
   assign w_gap_p1 = {1'b0, r_gap_cnt} + c_GAP_ONE;

   // Next-state, counter and strobe decode
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_ok        = 1'b0;
      w_err       = 1'b0;
      w_err_nxt   = r_err_code;
      case (r_state)
         IDLE: begin
            if (beam) begin
               w_state_nxt = ON;
               w_run_nxt   = c_RUN_ONE;
            end
         end
         ON: begin
            if (beam) begin
               if (r_run_cnt == c_PULSE_LEN) begin
                  // One sample too many: flag now, ignore the rest of it
                  w_err       = 1'b1;
                  w_err_nxt   = ERR_LONG;
                  w_state_nxt = OVER;
               end else begin
                  w_run_nxt = r_run_cnt + c_RUN_ONE;
               end
            end else begin
               if (r_run_cnt == c_PULSE_LEN) begin
                  w_ok = 1'b1;
               end else begin
                  w_err     = 1'b1;
                  w_err_nxt = ERR_SHORT;
               end
               if (c_GAP_SKIP) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = GAP;
                  w_gap_nxt   = c_RUN_ONE;
               end
            end
         end
         OVER: begin
            if (!beam) begin
               if (c_GAP_SKIP) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = GAP;
                  w_gap_nxt   = c_RUN_ONE;
               end
            end
         end
         GAP: begin
            if (beam) begin
               // Gap too short, but the new pulse is still measured
               w_err       = 1'b1;
               w_err_nxt   = ERR_GAP;
               w_state_nxt = ON;
               w_run_nxt   = c_RUN_ONE;
            end else if (w_gap_p1 >= c_MIN_GAP) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = w_gap_p1[CNT_W-1:0];
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_run_cnt   <= '0;
         r_gap_cnt   <= '0;
         r_pulse_ok  <= 1'b0;
         r_pulse_err <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_ok_count  <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_run_cnt   <= w_run_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_pulse_ok  <= w_ok;
         r_pulse_err <= w_err;
         r_err_code  <= w_err_nxt;
         if (w_ok) begin
            r_ok_count <= r_ok_count + 8'd1;
         end
      end
   end

   assign pulse_ok  = r_pulse_ok;
   assign pulse_err = r_pulse_err;
   assign err_code  = r_err_code;
   assign ok_count  = r_ok_count;
   assign busy      = (r_state != IDLE);

endmodule : laser_pulse_rx
`default_nettype wire

// File: tb/tb_laser_pulse_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_laser_pulse_rx
//  Description : Directed self-checking bench for laser_pulse_rx. Two
//                instances: MIN_GAP=1 and MIN_GAP=3, both PULSE_LEN=3.
//                Expected strobes are queued when stimulus is driven and
//                matched when the receiver reports a result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_pulse_rx;

   localparam int c_PL = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       beam;
   logic       beam3;

   logic       pulse_ok,  pulse_err,  busy;
   logic [1:0] err_code;
   logic [7:0] ok_count;
   logic       pulse_ok3, pulse_err3, busy3;
   logic [1:0] err_code3;
   logic [7:0] ok_count3;

   int tests = 0;
   int fails = 0;

   // Expected strobe record: {ok, err, err_code, ok_count}
   logic [11:0] q1[$];
   logic [11:0] q3[$];
   logic [7:0]  exp_cnt1, exp_cnt3;
   logic [1:0]  exp_code1, exp_code3;

   laser_pulse_rx #(.PULSE_LEN(c_PL), .MIN_GAP(1)) dut (
      .clk(clk), .rst(rst), .beam(beam),
      .pulse_ok(pulse_ok), .pulse_err(pulse_err), .err_code(err_code),
      .ok_count(ok_count), .busy(busy)
   );

   laser_pulse_rx #(.PULSE_LEN(c_PL), .MIN_GAP(3)) dut3 (
      .clk(clk), .rst(rst), .beam(beam3),
      .pulse_ok(pulse_ok3), .pulse_err(pulse_err3), .err_code(err_code3),
      .ok_count(ok_count3), .busy(busy3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic b);
      @(negedge clk);
      beam = b;
   endtask

   task automatic drive3(input logic b);
      @(negedge clk);
      beam3 = b;
   endtask

   task automatic exp_ok1();
      exp_cnt1 = exp_cnt1 + 8'd1;
      q1.push_back({1'b1, 1'b0, exp_code1, exp_cnt1});
   endtask

   task automatic exp_err1(input logic [1:0] code);
      exp_code1 = code;
      q1.push_back({1'b0, 1'b1, exp_code1, exp_cnt1});
   endtask

   task automatic exp_ok3();
      exp_cnt3 = exp_cnt3 + 8'd1;
      q3.push_back({1'b1, 1'b0, exp_code3, exp_cnt3});
   endtask

   task automatic exp_err3(input logic [1:0] code);
      exp_code3 = code;
      q3.push_back({1'b0, 1'b1, exp_code3, exp_cnt3});
   endtask

   // Pulse of n high samples then one low sample on the MIN_GAP=1 instance
   task automatic send_pulse(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1);
         if (i == c_PL) exp_err1(2'd2);
      end
      drive(1'b0);
      if (n == c_PL)     exp_ok1();
      else if (n < c_PL) exp_err1(2'd1);
   endtask

   // Scoreboard: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst && (pulse_ok || pulse_err)) begin
         if (q1.size() == 0) begin
            chk("dut_unexpected_strobe", {30'd0, pulse_ok, pulse_err}, 32'd0);
         end else begin
            e = q1.pop_front();
            chk("dut_strobe", {20'd0, pulse_ok, pulse_err, err_code, ok_count}, {20'd0, e});
         end
      end
   end

   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst && (pulse_ok3 || pulse_err3)) begin
         if (q3.size() == 0) begin
            chk("dut3_unexpected_strobe", {30'd0, pulse_ok3, pulse_err3}, 32'd0);
         end else begin
            e = q3.pop_front();
            chk("dut3_strobe", {20'd0, pulse_ok3, pulse_err3, err_code3, ok_count3}, {20'd0, e});
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; beam = 1'b0; beam3 = 1'b0;
      exp_cnt1 = 8'd0; exp_code1 = 2'd0;
      exp_cnt3 = 8'd0; exp_code3 = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      @(posedge clk); #1;
      chk("rst_pulse_ok",  {31'd0, pulse_ok},  32'd0);
      chk("rst_pulse_err", {31'd0, pulse_err}, 32'd0);
      chk("rst_err_code",  {30'd0, err_code},  32'd0);
      chk("rst_ok_count",  {24'd0, ok_count},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);

      // Good pulse
      drive(1'b1);
      @(posedge clk); #1;
      chk("good_busy_rise", {31'd0, busy}, 32'd1);
      drive(1'b1);
      drive(1'b1);
      drive(1'b0);
      exp_ok1();
      @(posedge clk); #1;
      chk("good_pulse_ok",  {31'd0, pulse_ok},  32'd1);
      chk("good_busy_low",  {31'd0, busy},      32'd0);
      chk("good_ok_count",  {24'd0, ok_count},  32'd1);
      chk("good_err_code",  {30'd0, err_code},  32'd0);
      @(posedge clk); #1;
      chk("good_one_cycle", {31'd0, pulse_ok},  32'd0);

      // Short pulse
      send_pulse(2);
      @(posedge clk); #1;
      chk("short_pulse_err", {31'd0, pulse_err}, 32'd1);
      chk("short_err_code",  {30'd0, err_code},  32'd1);
      chk("short_ok_count",  {24'd0, ok_count},  32'd1);
      drive(1'b0);

      // Long pulse: flagged on the 4th high sample, busy held until fall
      for (int i = 0; i < 6; i++) begin
         drive(1'b1);
         if (i == c_PL) exp_err1(2'd2);
         @(posedge clk); #1;
         chk("long_busy", {31'd0, busy}, 32'd1);
         if (i == c_PL) chk("long_err_code", {30'd0, err_code}, 32'd2);
      end
      drive(1'b0);
      @(posedge clk); #1;
      chk("long_busy_low",  {31'd0, busy},     32'd0);
      chk("long_no_ok",     {31'd0, pulse_ok}, 32'd0);
      chk("long_ok_count",  {24'd0, ok_count}, 32'd1);

      // Back-to-back good pulses with 1-cycle gaps until the count wraps
      for (int i = 0; i < 255; i++) send_pulse(c_PL);
      @(posedge clk); #1;
      chk("wrap_ok_count", {24'd0, ok_count}, 32'd0);
      chk("wrap_err_code", {30'd0, err_code}, 32'd2);
      send_pulse(c_PL);
      @(posedge clk); #1;
      chk("post_wrap_count", {24'd0, ok_count}, 32'd1);

      // MIN_GAP=3: gap violation, new pulse still measured
      drive3(1'b1); drive3(1'b1); drive3(1'b1);
      drive3(1'b0);
      exp_ok3();
      drive3(1'b1);
      exp_err3(2'd3);
      @(posedge clk); #1;
      chk("gap_err_code", {30'd0, err_code3}, 32'd3);
      chk("gap_busy",     {31'd0, busy3},     32'd1);
      drive3(1'b1); drive3(1'b1);
      drive3(1'b0);
      exp_ok3();
      @(posedge clk); #1;
      chk("gap_second_ok", {31'd0, pulse_ok3}, 32'd1);
      chk("gap_ok_count",  {24'd0, ok_count3}, 32'd2);
      repeat (4) @(posedge clk);
      #1;
      chk("gap_busy_drain", {31'd0, busy3}, 32'd0);

      // Asynchronous reset during the 2nd high cycle of a pulse
      drive(1'b1);
      drive(1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_pulse_ok",  {31'd0, pulse_ok},  32'd0);
      chk("arst_pulse_err", {31'd0, pulse_err}, 32'd0);
      chk("arst_err_code",  {30'd0, err_code},  32'd0);
      chk("arst_ok_count",  {24'd0, ok_count},  32'd0);
      chk("arst_busy",      {31'd0, busy},      32'd0);
      chk("arst_ok_count3", {24'd0, ok_count3}, 32'd0);
      exp_cnt1 = 8'd0; exp_code1 = 2'd0;
      exp_cnt3 = 8'd0; exp_code3 = 2'd0;
      @(negedge clk);
      beam = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send_pulse(c_PL);
      @(posedge clk); #1;
      chk("post_rst_ok",       {31'd0, pulse_ok}, 32'd1);
      chk("post_rst_ok_count", {24'd0, ok_count}, 32'd1);
      chk("post_rst_err_code", {30'd0, err_code}, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("q1_drained", q1.size(), 32'd0);
      chk("q3_drained", q3.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_laser_pulse_rx
`default_nettype wire

// File: doc/laser_pulse_rx.md
# laser_pulse_rx

Receiver-side checker for the laser beam driven by the laser timer. Samples the beam line on the shared clock, measures each high pulse and the low gap before the next, and classifies every pulse as good, short, long or gap-violating. Flags each result with a one-cycle strobe and counts good pulses. Sits on the optical-sensor side of the laser subsystem and feeds status to the top-level controller.

## Interface
- PULSE_LEN, 3: exact number of consecutive high cycles for a good pulse (≥1)
- MIN_GAP, 1: minimum number of low cycles required between two pulses (≥1)
- CNT_W, derived localparam: $clog2(max(PULSE_LEN, MIN_GAP)+1); not overridable
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- beam  input  1  laser beam level, synchronous to clk; no synchronizer inside
- pulse_ok  output  1  one-cycle strobe: good pulse completed
- pulse_err  output  1  one-cycle strobe: error detected
- err_code  output  2  last error: 0 none, 1 SHORT, 2 LONG, 3 GAP; held until next error
- ok_count  output  8  number of good pulses, wraps 255→0
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ON, OVER, GAP. run_cnt and gap_cnt are CNT_W-bit counters.
- IDLE: beam=1 → ON, run_cnt=1. beam=0 → stay.
- ON, beam=1, run_cnt<PULSE_LEN: run_cnt++.
- ON, beam=1, run_cnt==PULSE_LEN: LONG error, strobe pulse_err, err_code=2, go to OVER.
- ON, beam=0, run_cnt==PULSE_LEN: strobe pulse_ok, ok_count++.
- ON, beam=0, run_cnt<PULSE_LEN: SHORT error, strobe pulse_err, err_code=1.
- ON, beam=0, either case: go to GAP with gap_cnt=1. If MIN_GAP==1, go straight to IDLE instead.
- OVER: beam=1 → stay; no further strobes for the same pulse. beam=0 → GAP/IDLE, same rule as ON falling. No pulse_ok.
- GAP, beam=0: if gap_cnt+1 ≥ MIN_GAP → IDLE, else gap_cnt++.
- GAP, beam=1: GAP error, strobe pulse_err, err_code=3. Go to ON with run_cnt=1, so the new pulse is still measured and classified.
- At most one strobe per cycle. pulse_ok and pulse_err are never high together.
- busy is decoded combinationally from state. All other outputs are registered.

## Timing
- Reset values: state IDLE, run_cnt 0, gap_cnt 0, pulse_ok 0, pulse_err 0, err_code 0, ok_count 0, busy 0.
- Reset mid-pulse discards the measurement: no strobe, and counters clear immediately (asynchronous).
- Latency: the event is sampled at edge k. The strobe, err_code update and ok_count increment are all visible after edge k, for exactly one cycle for the strobes.
- Good pulse, PULSE_LEN=3:
  - beam high when sampled at edges k, k+1, k+2 and low at edge k+3.
  - pulse_ok is high in the cycle after edge k+3.
  - busy rises after edge k.
- A long pulse is flagged at the (PULSE_LEN+1)-th high sample, not at the falling edge.
- Back-to-back good pulses with a 1-cycle gap are legal at MIN_GAP=1.
- Wrap: ok_count 255 plus one good pulse gives 0, with no flag.

## Structure
- Shared package laser_pkg holds:
  - state enum (IDLE, ON, OVER, GAP), 2 bits
  - err_code enum (ERR_NONE, ERR_SHORT, ERR_LONG, ERR_GAP), 2 bits
- Single module with no sub-modules:
  - one always_ff for state, counters and registered outputs
  - one always_comb for next-state and strobe decode

## Test plan
- Reset, then beam high for 3 cycles, then low → pulse_ok one cycle after the falling sample; ok_count=1; err_code=0; busy back to 0 the same cycle pulse_ok rises.
- Beam high for 2 cycles → pulse_err with err_code=1 after the falling sample; ok_count unchanged.
- Beam high for 6 cycles → pulse_err with err_code=2 after the 4th high sample, exactly once; no pulse_ok; busy stays 1 until beam falls.
- MIN_GAP=3: good pulse, beam low 1 cycle, then a 3-cycle pulse → pulse_err with err_code=3 on the rising sample, then pulse_ok for the second pulse; ok_count=2.
- 256 good pulses with 1-cycle gaps → ok_count wraps to 0; no pulse_err at any point.
- Assert rst during the 2nd high cycle of a pulse → all outputs 0 immediately; the next 3-cycle pulse gives a normal pulse_ok.
